// File: rtl/seq_factorial.sv
// Multi-cycle n! unit: one WIDTH x WIDTH multiply per clock, start/ready/done handshake,
// sticky overflow and optional saturation of the result.
module seq_factorial #(
  parameter int WIDTH    = 6,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

  state_t             state_q;
  logic [WIDTH-1:0]   n_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   k_q;
  logic               ovf_q;
  logic               ready_q;
  logic               done_q;
  logic [WIDTH-1:0]   out_q;
  logic               overflow_q;

  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   acc_d;
  logic               ovf_d;

  // Any nonzero upper half means the true n! no longer fits, even if the low half wraps to 0.
  always_comb begin
    prod_d = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, k_q};
    acc_d  = prod_d[WIDTH-1:0];
    ovf_d  = ovf_q | (|prod_d[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FIN: begin
          ready_q <= 1'b1;
          if (start) begin
            n_q   <= ain;
            acc_q <= ONE;
            k_q   <= TWO;
            ovf_q <= 1'b0;
            if (ain <= ONE) begin
              state_q    <= FIN;
              done_q     <= 1'b1;
              out_q      <= ONE;
              overflow_q <= 1'b0;
            end else begin
              state_q <= CALC;
              ready_q <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
          end
        end

        // Equality on k (not k > n) keeps n = 2^WIDTH-1 from needing a wider counter.
        CALC: begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          if (k_q == n_q) begin
            state_q    <= FIN;
            ready_q    <= 1'b1;
            done_q     <= 1'b1;
            out_q      <= (SATURATE && ovf_d) ? ONES : acc_d;
            overflow_q <= ovf_d;
          end else begin
            k_q     <= k_q + ONE;
            ready_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign out      = out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_factorial.sv
// Directed bench for seq_factorial: four instances (6-bit wrap, 8-bit saturate,
// 8-bit wrap, 4-bit wrap) share clock, reset and operand bus.
module tb_seq_factorial;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ainBus;
  logic       start6, start8s, start8w, start4;

  logic       ready6, done6, ovf6;
  logic [5:0] out6;
  logic       ready8s, done8s, ovf8s;
  logic [7:0] out8s;
  logic       ready8w, done8w, ovf8w;
  logic [7:0] out8w;
  logic       ready4, done4, ovf4;
  logic [3:0] out4;

  int         sel;
  logic       readySel, doneSel, ovfSel;
  logic [7:0] outSel;

  int checks   = 0;
  int failures = 0;

  // Hand-computed n! mod 64 for n = 0..7; every n >= 8 gives 0.
  int fact6[8] = '{1, 1, 2, 6, 24, 56, 16, 48};

  always #5 clk = ~clk;

  seq_factorial #(.WIDTH(6), .SATURATE(1'b0)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .ain(ainBus[5:0]),
    .ready(ready6), .done(done6), .out(out6), .overflow(ovf6));

  seq_factorial #(.WIDTH(8), .SATURATE(1'b1)) dut8s (
    .clk(clk), .rst(rst), .start(start8s), .ain(ainBus),
    .ready(ready8s), .done(done8s), .out(out8s), .overflow(ovf8s));

  seq_factorial #(.WIDTH(8), .SATURATE(1'b0)) dut8w (
    .clk(clk), .rst(rst), .start(start8w), .ain(ainBus),
    .ready(ready8w), .done(done8w), .out(out8w), .overflow(ovf8w));

  seq_factorial #(.WIDTH(4), .SATURATE(1'b0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .ain(ainBus[3:0]),
    .ready(ready4), .done(done4), .out(out4), .overflow(ovf4));

  always_comb begin
    readySel = 1'b0;
    doneSel  = 1'b0;
    ovfSel   = 1'b0;
    outSel   = '0;
    case (sel)
      0: begin readySel = ready6;  doneSel = done6;  ovfSel = ovf6;  outSel = {2'b00, out6}; end
      1: begin readySel = ready8s; doneSel = done8s; ovfSel = ovf8s; outSel = out8s; end
      2: begin readySel = ready8w; doneSel = done8w; ovfSel = ovf8w; outSel = out8w; end
      3: begin readySel = ready4;  doneSel = done4;  ovfSel = ovf4;  outSel = {4'b0000, out4}; end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setStart(input int s, input logic v);
    case (s)
      0: start6  = v;
      1: start8s = v;
      2: start8w = v;
      3: start4  = v;
      default: ;
    endcase
  endtask

  // Presents one start pulse; returns #1 after the accepting edge.
  task automatic applyStimulus(input int s, input int n);
    sel = s;
    @(negedge clk);
    ainBus = 8'(n);
    setStart(s, 1'b1);
    @(posedge clk);
    #1;
    setStart(s, 1'b0);
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic waitDone(output int cyc);
    cyc = 1;
    while (!doneSel && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic runOp(input int s, input int n, input int expOut, input bit expOvf,
                       input int expLat, input string tag);
    int cyc;
    applyStimulus(s, n);
    waitDone(cyc);
    checkOutput({tag, ".lat"}, cyc, expLat);
    checkOutput({tag, ".out"}, outSel, expOut);
    checkOutput({tag, ".ovf"}, ovfSel, expOvf);
    @(posedge clk);
    #1;
    checkOutput({tag, ".donePulse"}, doneSel, 0);
    checkOutput({tag, ".hold"}, outSel, expOut);
  endtask

  initial begin
    int cyc;
    bit sawDone;
    rst = 1'b1;
    ainBus = '0;
    start6 = 1'b0; start8s = 1'b0; start8w = 1'b0; start4 = 1'b0;
    sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset.ready", readySel, 1);
    checkOutput("reset.done", doneSel, 0);
    checkOutput("reset.out", outSel, 0);
    checkOutput("reset.ovf", ovfSel, 0);

    // Full 6-bit sweep against the combinational unit's values.
    for (int n = 0; n < 64; n++) begin
      runOp(0, n, (n < 8) ? fact6[n] : 0, (n >= 5), (n <= 1) ? 1 : n, $sformatf("w6.n%0d", n));
    end

    runOp(1, 5, 120, 1'b0, 5, "w8sat.n5");
    runOp(1, 6, 255, 1'b1, 6, "w8sat.n6");
    runOp(2, 6, 208, 1'b1, 6, "w8wrap.n6");

    // Start pulse during CALC must be ignored.
    applyStimulus(0, 4);
    checkOutput("busy.ready", readySel, 0);
    @(posedge clk);
    #1;
    start6 = 1'b1;
    ainBus = 8'd2;
    @(posedge clk);
    #1;
    start6 = 1'b0;
    cyc = 3;
    while (!doneSel && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("busy.lat", cyc, 4);
    checkOutput("busy.out", outSel, 24);
    checkOutput("busy.ovf", ovfSel, 0);

    // Start held through FIN: back-to-back acceptance.
    sel = 0;
    @(negedge clk);
    ainBus = 8'd3;
    start6 = 1'b1;
    @(posedge clk);
    #1;
    waitDone(cyc);
    checkOutput("b2b.lat1", cyc, 3);
    checkOutput("b2b.out1", outSel, 6);
    @(posedge clk);
    #1;
    checkOutput("b2b.accepted", readySel, 0);
    checkOutput("b2b.noDone", doneSel, 0);
    start6 = 1'b0;
    ainBus = 8'd0;
    cyc = 1;
    while (!doneSel && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("b2b.lat2", cyc, 3);
    checkOutput("b2b.out2", outSel, 6);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("b2b.holdOut", outSel, 6);
    checkOutput("b2b.holdOvf", ovfSel, 0);
    checkOutput("b2b.holdDone", doneSel, 0);

    // Reset mid-computation aborts silently.
    runOp(0, 5, 56, 1'b1, 5, "preRst.n5");
    applyStimulus(0, 10);
    sawDone = doneSel;
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk);
      #1;
      sawDone = sawDone | doneSel;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstMid.noDoneBefore", sawDone, 0);
    checkOutput("rstMid.done", doneSel, 0);
    checkOutput("rstMid.out", outSel, 0);
    checkOutput("rstMid.ovf", ovfSel, 0);
    checkOutput("rstMid.ready", readySel, 1);
    runOp(0, 3, 6, 1'b0, 3, "postRst.n3");

    // 4-bit boundaries: k must count up to 15 without wrapping.
    runOp(3, 15, 0, 1'b1, 15, "w4.n15");
    runOp(3, 1, 1, 1'b0, 1, "w4.n1");
    runOp(3, 0, 1, 1'b0, 1, "w4.n0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
